// File: rtl/swizzle_pipe_if.sv
// Request/result bundle for swizzle_pipe: request side (iValid/oReady + operands),
// result side (oValid/iReady + oResult) and the synchronous flush.
interface swizzle_pipe_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 3,
  parameter int SEL_W = 2
);
  logic                     iFlush;
  logic                     iValid;
  logic                     oReady;
  logic [LANES*WIDTH-1:0]   iSource;
  logic [LANES*SEL_W-1:0]   iSelect;
  logic [LANES-1:0]         iNegate;
  logic [LANES-1:0]         iZero;
  logic                     oValid;
  logic                     iReady;
  logic [LANES*WIDTH-1:0]   oResult;

  modport master (
    output iFlush, iValid, iSource, iSelect, iNegate, iZero, iReady,
    input  oReady, oValid, oResult
  );

  modport slave (
    input  iFlush, iValid, iSource, iSelect, iNegate, iZero, iReady,
    output oReady, oValid, oResult
  );
endinterface

// File: rtl/swizzle_pipe.sv
// Per-lane vector swizzle (select / negate / zero) feeding a 2-entry result FIFO
// with valid/ready on both sides; all outputs come straight from registers.
module swizzle_pipe #(
  parameter int WIDTH = 32,
  parameter int LANES = 3,
  parameter int SEL_W = 2
) (
  input logic         Clock,
  input logic         Reset,
  swizzle_pipe_if.slave bus
);
  localparam int DW = LANES * WIDTH;

  logic [DW-1:0] lane_s;
  logic          push_s;
  logic          pop_s;

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    occ_q, occ_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] res_q, res_d;

  // Out-of-range selectors yield zero; zero beats negate; negate wraps modulo 2**WIDTH.
  function automatic logic [DW-1:0] swizzle(
    input logic [DW-1:0]          src,
    input logic [LANES*SEL_W-1:0] sel,
    input logic [LANES-1:0]       neg,
    input logic [LANES-1:0]       zero
  );
    logic [DW-1:0]    res;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] v;
    res = {DW{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      idx = sel[k*SEL_W +: SEL_W];
      v   = {WIDTH{1'b0}};
      for (int j = 0; j < LANES; j++) begin
        if (int'(idx) == j) begin
          v = src[j*WIDTH +: WIDTH];
        end else begin
          v = v;
        end
      end
      if (zero[k]) begin
        v = {WIDTH{1'b0}};
      end else if (neg[k]) begin
        v = {WIDTH{1'b0}} - v;
      end else begin
        v = v;
      end
      res[k*WIDTH +: WIDTH] = v;
    end
    return res;
  endfunction

  // Lane datapath for the request currently on the bus.
  always_comb begin
    lane_s = swizzle(bus.iSource, bus.iSelect, bus.iNegate, bus.iZero);
  end

  // FIFO next state; flush wins over push and pop, and output registers track the next head.
  always_comb begin
    push_s = bus.iValid && ready_q;
    pop_s  = valid_q && bus.iReady;
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (bus.iFlush) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      occ_d  = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          mem_d[wptr_q] = lane_s;
          wptr_d        = ~wptr_q;
          occ_d         = occ_q + 2'd1;
        end
        2'b01: begin
          rptr_d = ~rptr_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          mem_d[wptr_q] = lane_s;
          wptr_d        = ~wptr_q;
          rptr_d        = ~rptr_q;
        end
        default: begin
          occ_d = occ_q;
        end
      endcase
    end
    ready_d = (occ_d != 2'd2);
    valid_d = (occ_d != 2'd0);
    if (occ_d != 2'd0) begin
      res_d = mem_d[rptr_d];
    end else begin
      res_d = {DW{1'b0}};
    end
  end

  // State registers; reset holds oReady low until the first edge after release.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      occ_q   <= 2'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  assign bus.oReady  = ready_q;
  assign bus.oValid  = valid_q;
  assign bus.oResult = res_q;
endmodule

// File: tb/tb_swizzle_pipe.sv
// Directed bench for swizzle_pipe: table of single-request vectors plus
// hand-written backpressure, streaming, flush and reset sequences.
module tb_swizzle_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  swizzle_pipe_if #(.WIDTH(32), .LANES(3), .SEL_W(2)) bus ();

  swizzle_pipe #(.WIDTH(32), .LANES(3), .SEL_W(2)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [95:0] src;
    logic [5:0]  sel;
    logic [2:0]  neg;
    logic [2:0]  zero;
    logic [95:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [95:0] src, input logic [5:0] sel,
                       input logic [2:0] neg, input logic [2:0] zero);
    bus.iSource = src;
    bus.iSelect = sel;
    bus.iNegate = neg;
    bus.iZero   = zero;
  endtask

  initial begin
    logic [95:0] a_v, b_v, c_v, r_v;
    checks = 0;
    errors = 0;

    vecs[0] = '{"identity", {32'd3, 32'd2, 32'd1}, {2'd2, 2'd1, 2'd0}, 3'b000, 3'b000,
                {32'd3, 32'd2, 32'd1}};
    vecs[1] = '{"broadcast_y", {32'd3, 32'd2, 32'd1}, {2'd1, 2'd1, 2'd1}, 3'b000, 3'b000,
                {32'd2, 32'd2, 32'd2}};
    vecs[2] = '{"zxy", {32'd3, 32'd2, 32'd1}, {2'd2, 2'd0, 2'd1}, 3'b000, 3'b000,
                {32'd3, 32'd1, 32'd2}};
    vecs[3] = '{"sel3_zero", {32'd3, 32'd2, 32'd1}, {2'd3, 2'd0, 2'd2}, 3'b000, 3'b000,
                {32'd0, 32'd1, 32'd3}};
    vecs[4] = '{"modifiers", {32'd0, 32'd0, 32'd5}, {2'd0, 2'd0, 2'd0}, 3'b011, 3'b100,
                {32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFB}};
    vecs[5] = '{"neg_min_wrap", {32'd0, 32'd0, 32'h8000_0000}, {2'd0, 2'd0, 2'd0}, 3'b111, 3'b010,
                {32'h8000_0000, 32'd0, 32'h8000_0000}};
    vecs[6] = '{"reverse_neg", {32'hAAAA_0000, 32'h1234_5678, 32'd1}, {2'd0, 2'd1, 2'd2}, 3'b010, 3'b000,
                {32'd1, 32'hEDCB_A988, 32'hAAAA_0000}};
    vecs[7] = '{"all_sel3", {32'd7, 32'd8, 32'd9}, {2'd3, 2'd3, 2'd3}, 3'b101, 3'b000,
                {32'd0, 32'd0, 32'd0}};

    rst_n       = 1'b0;
    bus.iFlush  = 1'b0;
    bus.iValid  = 1'b0;
    bus.iReady  = 1'b1;
    drive({96{1'b0}}, 6'd0, 3'd0, 3'd0);

    // Reset state, including across clock edges.
    #2;
    chk("rst_ovalid", {95'd0, bus.oValid}, 96'd0);
    chk("rst_oready", {95'd0, bus.oReady}, 96'd0);
    chk("rst_oresult", bus.oResult, 96'd0);
    step();
    step();
    chk("rst_held_oready", {95'd0, bus.oReady}, 96'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_oready_before_edge", {95'd0, bus.oReady}, 96'd0);
    step();
    chk("rel_oready_after_edge", {95'd0, bus.oReady}, 96'd1);
    chk("rel_ovalid", {95'd0, bus.oValid}, 96'd0);

    // Table-driven lane function, one-cycle latency, then drain.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].src, vecs[i].sel, vecs[i].neg, vecs[i].zero);
      bus.iValid = 1'b1;
      step();
      bus.iValid = 1'b0;
      chk({vecs[i].name, "_ovalid"}, {95'd0, bus.oValid}, 96'd1);
      chk(vecs[i].name, bus.oResult, vecs[i].exp);
      step();
      chk({vecs[i].name, "_drained"}, {95'd0, bus.oValid}, 96'd0);
      chk({vecs[i].name, "_zero_out"}, bus.oResult, 96'd0);
    end

    // Backpressure: A,B fill the FIFO, C is refused until oReady rises.
    a_v = {32'd11, 32'd12, 32'd13};
    b_v = {32'd21, 32'd22, 32'd23};
    c_v = {32'd31, 32'd32, 32'd33};
    bus.iReady = 1'b0;
    bus.iValid = 1'b1;
    drive(a_v, {2'd2, 2'd1, 2'd0}, 3'd0, 3'd0);
    step();
    chk("bp_a_head", bus.oResult, a_v);
    chk("bp_a_oready", {95'd0, bus.oReady}, 96'd1);
    drive(b_v, {2'd2, 2'd1, 2'd0}, 3'd0, 3'd0);
    step();
    chk("bp_full_oready", {95'd0, bus.oReady}, 96'd0);
    chk("bp_full_head", bus.oResult, a_v);
    drive(c_v, {2'd2, 2'd1, 2'd0}, 3'd0, 3'd0);
    step();
    chk("bp_c_refused_oready", {95'd0, bus.oReady}, 96'd0);
    chk("bp_c_refused_head", bus.oResult, a_v);
    bus.iReady = 1'b1;
    step();
    chk("bp_pop_a_head_b", bus.oResult, b_v);
    chk("bp_pop_a_oready", {95'd0, bus.oReady}, 96'd1);
    step();
    chk("bp_c_head", bus.oResult, c_v);
    chk("bp_c_ovalid", {95'd0, bus.oValid}, 96'd1);
    bus.iValid = 1'b0;
    step();
    chk("bp_drained", {95'd0, bus.oValid}, 96'd0);

    // Streaming: one result per cycle in order, occupancy stays at one.
    bus.iValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r_v = {32'd0, 32'd0, 32'(100 + i)};
      drive(r_v, {2'd2, 2'd1, 2'd0}, 3'd0, 3'd0);
      step();
      chk($sformatf("stream_%0d", i), bus.oResult, r_v);
      chk($sformatf("stream_rdy_%0d", i), {94'd0, bus.oValid, bus.oReady}, 96'd3);
    end
    bus.iValid = 1'b0;
    step();
    chk("stream_drained", {95'd0, bus.oValid}, 96'd0);

    // Flush from full with a request present.
    bus.iReady = 1'b0;
    bus.iValid = 1'b1;
    drive(a_v, {2'd2, 2'd1, 2'd0}, 3'd0, 3'd0);
    step();
    step();
    chk("fl_full", {95'd0, bus.oReady}, 96'd0);
    bus.iFlush = 1'b1;
    step();
    chk("fl_ovalid", {95'd0, bus.oValid}, 96'd0);
    chk("fl_oready", {95'd0, bus.oReady}, 96'd1);
    chk("fl_oresult", bus.oResult, 96'd0);
    // Flush while a request is accepted: it is discarded.
    bus.iReady = 1'b1;
    step();
    chk("fl_accept_discard", {95'd0, bus.oValid}, 96'd0);
    bus.iFlush = 1'b0;
    bus.iValid = 1'b0;
    step();
    chk("fl_nothing_emitted", {95'd0, bus.oValid}, 96'd0);

    // Asynchronous reset mid-stream.
    bus.iReady = 1'b0;
    bus.iValid = 1'b1;
    drive(b_v, {2'd2, 2'd1, 2'd0}, 3'd0, 3'd0);
    step();
    chk("mr_loaded", bus.oResult, b_v);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_ovalid", {95'd0, bus.oValid}, 96'd0);
    chk("mr_oready", {95'd0, bus.oReady}, 96'd0);
    chk("mr_oresult", bus.oResult, 96'd0);
    bus.iValid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("mr_rel_oready_low", {95'd0, bus.oReady}, 96'd0);
    step();
    chk("mr_rel_oready_high", {95'd0, bus.oReady}, 96'd1);
    chk("mr_dropped", {95'd0, bus.oValid}, 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
